// File: rtl/spi_xfer_ctrl.sv
// SPI transaction sequencer: frames a 1..NBYTES_MAX byte exchange under SS with
// programmable setup/gap delays, per-byte handshake timeout and a DONE strobe.
module spi_xfer_ctrl #(
  parameter int unsigned NBYTES_MAX = 5,
  parameter int unsigned LEN_W      = 3,
  parameter int unsigned SS_SETUP   = 2,
  parameter int unsigned GAP_CYC    = 1,
  parameter int unsigned TO_CYC     = 255
) (
  input  logic                    CLK,
  input  logic                    RSTN,
  input  logic                    START,
  input  logic [LEN_W-1:0]        LEN,
  input  logic [8*NBYTES_MAX-1:0] DIN,
  input  logic                    BUSY,
  input  logic [7:0]              RxData,
  output logic                    SS,
  output logic                    getByte,
  output logic [7:0]              sndData,
  output logic [8*NBYTES_MAX-1:0] DOUT,
  output logic                    DONE,
  output logic                    ERR
);
  localparam int unsigned DW      = 8 * NBYTES_MAX;
  localparam int unsigned CNT_MAX = (SS_SETUP > GAP_CYC) ? SS_SETUP : GAP_CYC;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int unsigned TO_W    = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;

  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'((SS_SETUP != 0) ? SS_SETUP - 1 : 0);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((GAP_CYC != 0) ? GAP_CYC - 1 : 0);
  localparam logic [TO_W-1:0]  TO_LAST    = TO_W'((TO_CYC != 0) ? TO_CYC - 1 : 0);
  localparam logic [LEN_W-1:0] LEN_MAX    = LEN_W'(NBYTES_MAX);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_REQ, S_WAIT, S_CAPTURE, S_GAP, S_FIN, S_HOLD
  } state_e;

  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic [LEN_W-1:0] idx_inc;
  logic [DW-1:0]    din_q, din_d;
  logic [DW-1:0]    shadow_q, shadow_d;
  logic [DW-1:0]    dout_q, dout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic [7:0]       snd_q, snd_d;
  logic             err_q, err_d;
  logic             load_req;
  logic [7:0]       byte_sel;

  assign idx_inc = idx_q + LEN_W'(1);

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q  <= S_IDLE;
      len_q    <= '0;
      idx_q    <= '0;
      din_q    <= '0;
      shadow_q <= '0;
      dout_q   <= '0;
      cnt_q    <= '0;
      to_q     <= '0;
      snd_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      len_q    <= len_d;
      idx_q    <= idx_d;
      din_q    <= din_d;
      shadow_q <= shadow_d;
      dout_q   <= dout_d;
      cnt_q    <= cnt_d;
      to_q     <= to_d;
      snd_q    <= snd_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    idx_d    = idx_q;
    din_d    = din_q;
    shadow_d = shadow_q;
    dout_d   = dout_q;
    cnt_d    = cnt_q;
    to_d     = to_q;
    snd_d    = snd_q;
    err_d    = err_q;
    load_req = 1'b0;
    byte_sel = '0;

    case (state_q)
      S_IDLE: begin
        if (START) begin
          len_d    = LEN;
          din_d    = DIN;
          err_d    = 1'b0;
          shadow_d = '0;
          idx_d    = '0;
          if (LEN == '0 || LEN > LEN_MAX) begin
            err_d   = 1'b1;
            state_d = S_FIN;
          end else if (SS_SETUP == 0) begin
            load_req = 1'b1;
          end else begin
            cnt_d   = SETUP_LAST;
            state_d = S_SETUP;
          end
        end
      end
      S_SETUP: begin
        if (cnt_q == '0) load_req = 1'b1;
        else             cnt_d = cnt_q - CNT_W'(1);
      end
      S_REQ: begin
        if (BUSY) begin
          to_d    = '0;
          state_d = S_WAIT;
        end else if (TO_CYC != 0 && to_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = S_FIN;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      S_WAIT: begin
        if (!BUSY) begin
          state_d = S_CAPTURE;
        end else if (TO_CYC != 0 && to_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = S_FIN;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      S_CAPTURE: begin
        for (int unsigned k = 0; k < NBYTES_MAX; k++)
          if (idx_q == LEN_W'(k)) shadow_d[8*k +: 8] = RxData;
        idx_d = idx_inc;
        if (idx_inc == len_q) begin
          state_d = S_FIN;
        end else if (GAP_CYC == 0) begin
          load_req = 1'b1;
        end else begin
          cnt_d   = GAP_LAST;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (cnt_q == '0) load_req = 1'b1;
        else             cnt_d = cnt_q - CNT_W'(1);
      end
      S_FIN: begin
        if (!err_q) dout_d = shadow_q;
        state_d = S_HOLD;
      end
      S_HOLD: begin
        if (!START) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Every REQ entry funnels through here so sndData and the timeout reload stay in one place.
    for (int unsigned k = 0; k < NBYTES_MAX; k++)
      if (idx_d == LEN_W'(k)) byte_sel = din_d[8*k +: 8];
    if (load_req) begin
      state_d = S_REQ;
      to_d    = '0;
      snd_d   = byte_sel;
    end
  end

  assign SS      = !(state_q inside {S_SETUP, S_REQ, S_WAIT, S_CAPTURE, S_GAP});
  assign getByte = (state_q == S_REQ);
  assign DONE    = (state_q == S_FIN);
  assign sndData = snd_q;
  assign DOUT    = dout_q;
  assign ERR     = err_q;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Self-checking bench for spi_xfer_ctrl: table vectors, reset corner case and
// randomized transactions against a frame-level reference model.
module tb_spi_xfer_ctrl;
  localparam int unsigned NB    = 5;
  localparam int unsigned SETUP = 2;
  localparam int unsigned GAP   = 1;
  localparam int unsigned TO    = 16;

  logic          CLK = 1'b0;
  logic          RSTN;
  logic          START;
  logic [2:0]    LEN;
  logic [39:0]   DIN;
  logic          BUSY;
  logic [7:0]    RxData;
  logic          SS;
  logic          getByte;
  logic [7:0]    sndData;
  logic [39:0]   DOUT;
  logic          DONE;
  logic          ERR;

  int checks   = 0;
  int failures = 0;

  spi_xfer_ctrl #(
    .NBYTES_MAX(NB),
    .LEN_W     (3),
    .SS_SETUP  (SETUP),
    .GAP_CYC   (GAP),
    .TO_CYC    (TO)
  ) dut (
    .CLK    (CLK),
    .RSTN   (RSTN),
    .START  (START),
    .LEN    (LEN),
    .DIN    (DIN),
    .BUSY   (BUSY),
    .RxData (RxData),
    .SS     (SS),
    .getByte(getByte),
    .sndData(sndData),
    .DOUT   (DOUT),
    .DONE   (DONE),
    .ERR    (ERR)
  );

  always #5 CLK = ~CLK;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Byte engine: accepts a request, waits eng_L cycles, stays busy eng_B cycles, returns ~TX.
  int unsigned eng_L = 0;
  int unsigned eng_B = 1;
  bit          eng_en = 1'b1;
  bit          eng_busy = 1'b0;
  logic [7:0]  tx_q[$];

  initial begin
    logic [7:0] tx;
    BUSY   = 1'b0;
    RxData = '0;
    forever begin
      @(negedge CLK);
      if (eng_en && getByte && !eng_busy) begin
        eng_busy = 1'b1;
        tx = sndData;
        tx_q.push_back(tx);
        repeat (eng_L) @(negedge CLK);
        BUSY = 1'b1;
        repeat (eng_B) @(negedge CLK);
        RxData = tx ^ 8'hFF;
        BUSY = 1'b0;
        eng_busy = 1'b0;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] lane_mask(input int unsigned len);
    return (64'd1 << (8 * len)) - 64'd1;
  endfunction

  // Frame-level expectations, derived from the transaction rules rather than cycle state.
  typedef struct {
    bit            err;
    logic [39:0]   dout;
    int unsigned   ss;
    int unsigned   gb;
    int unsigned   ntx;
    logic [63:0]   tx;
  } exp_t;

  function automatic exp_t model(input int unsigned len, input logic [39:0] din,
                                 input int unsigned lat, input int unsigned bl,
                                 input bit en, input logic [39:0] prev);
    exp_t e;
    e.dout = prev;
    e.tx   = '0;
    e.ntx  = 0;
    if (len == 0 || len > NB) begin
      e.err = 1'b1; e.ss = 0; e.gb = 0;
    end else if (!en) begin
      e.err = 1'b1; e.ss = SETUP + TO; e.gb = TO;
    end else begin
      e.err  = 1'b0;
      e.dout = 40'((64'(din) ^ 64'hFF_FFFF_FFFF) & lane_mask(len));
      e.ss   = SETUP + len * (lat + 1 + bl + 1) + (len - 1) * GAP;
      e.gb   = len * (lat + 1);
      e.ntx  = len;
      e.tx   = 64'(din) & lane_mask(len);
    end
    return e;
  endfunction

  int unsigned r_done, r_ss, r_gb;
  bit          r_err, r_seen, r_ss_end, r_gb_end;
  logic [39:0] r_dout;

  task automatic sample_cycle();
    @(negedge CLK);
    if (!SS)     r_ss++;
    if (getByte) r_gb++;
    if (DONE)    r_done++;
    LEN = 3'($urandom);
    DIN = 40'({$urandom, $urandom});
  endtask

  task automatic run_xfer(input logic [2:0] len, input logic [39:0] din, input int unsigned lat,
                          input int unsigned bl, input bit en, input int unsigned hold);
    int unsigned n;
    eng_L = lat; eng_B = bl; eng_en = en;
    tx_q.delete();
    r_done = 0; r_ss = 0; r_gb = 0; r_seen = 1'b0;
    @(negedge CLK);
    LEN = len; DIN = din; START = 1'b1;
    n = 0;
    while (r_done == 0 && n < 3000) begin
      sample_cycle();
      n++;
    end
    r_seen = (r_done != 0);
    sample_cycle();
    r_dout = DOUT;
    r_err  = ERR;
    repeat (hold) sample_cycle();
    START = 1'b0;
    repeat (2) sample_cycle();
    r_ss_end = SS;
    r_gb_end = getByte;
    n = 0;
    while (eng_busy && n < 100) begin
      @(negedge CLK);
      n++;
    end
  endtask

  task automatic check_run(input string tag, input exp_t e);
    logic [63:0] txp;
    txp = '0;
    for (int i = 0; i < tx_q.size() && i < 8; i++) txp |= 64'(tx_q[i]) << (8 * i);
    check({tag, "_done_seen"}, 64'(r_seen), 64'd1);
    check({tag, "_done_pulses"}, 64'(r_done), 64'd1);
    check({tag, "_err"}, 64'(r_err), 64'(e.err));
    check({tag, "_dout"}, 64'(r_dout), 64'(e.dout));
    check({tag, "_ss_low_cycles"}, 64'(r_ss), 64'(e.ss));
    check({tag, "_getbyte_cycles"}, 64'(r_gb), 64'(e.gb));
    check({tag, "_tx_count"}, 64'(tx_q.size()), 64'(e.ntx));
    check({tag, "_tx_bytes"}, txp, e.tx);
    check({tag, "_ss_idle"}, 64'(r_ss_end), 64'd1);
    check({tag, "_getbyte_idle"}, 64'(r_gb_end), 64'd0);
  endtask

  typedef struct {
    logic [2:0]  len;
    logic [39:0] din;
    int unsigned lat;
    int unsigned bl;
    bit          en;
    int unsigned hold;
    bit          exp_err;
    logic [39:0] exp_dout;
    int unsigned exp_ss;
    int unsigned exp_gb;
  } vec_t;

  vec_t vecs[8];

  initial begin
    exp_t        e;
    logic [39:0] prev;
    int unsigned n;
    logic [2:0]  rl;
    logic [39:0] rd;
    int unsigned ra, rb, rh;
    bit          ren;

    vecs[0] = '{3'd5, 40'h0504030201, 0, 8, 1'b1, 0,   1'b0, 40'hFAFBFCFDFE, 56, 5};
    vecs[1] = '{3'd2, 40'h0504030201, 0, 8, 1'b1, 0,   1'b0, 40'h000000FDFE, 23, 2};
    vecs[2] = '{3'd0, 40'h0504030201, 0, 8, 1'b1, 0,   1'b1, 40'h000000FDFE, 0,  0};
    vecs[3] = '{3'd6, 40'h0504030201, 0, 8, 1'b1, 0,   1'b1, 40'h000000FDFE, 0,  0};
    vecs[4] = '{3'd3, 40'h1122334455, 0, 1, 1'b0, 0,   1'b1, 40'h000000FDFE, 18, 16};
    vecs[5] = '{3'd1, 40'h00000000AA, 2, 3, 1'b1, 200, 1'b0, 40'h0000000055, 9,  3};
    vecs[6] = '{3'd3, 40'h0000C35A0F, 1, 1, 1'b1, 0,   1'b0, 40'h00003CA5F0, 16, 6};
    vecs[7] = '{3'd7, 40'hFFFFFFFFFF, 0, 2, 1'b1, 0,   1'b1, 40'h00003CA5F0, 0,  0};

    RSTN = 1'b0; START = 1'b0; LEN = '0; DIN = '0;
    repeat (3) @(negedge CLK);
    check("reset_ss", 64'(SS), 64'd1);
    check("reset_getbyte", 64'(getByte), 64'd0);
    check("reset_snddata", 64'(sndData), 64'd0);
    check("reset_dout", 64'(DOUT), 64'd0);
    check("reset_done", 64'(DONE), 64'd0);
    check("reset_err", 64'(ERR), 64'd0);
    RSTN = 1'b1;
    @(negedge CLK);

    for (int i = 0; i < 8; i++) begin
      run_xfer(vecs[i].len, vecs[i].din, vecs[i].lat, vecs[i].bl, vecs[i].en, vecs[i].hold);
      e.err  = vecs[i].exp_err;
      e.dout = vecs[i].exp_dout;
      e.ss   = vecs[i].exp_ss;
      e.gb   = vecs[i].exp_gb;
      e.ntx  = (vecs[i].exp_err || !vecs[i].en) ? 0 : int'(vecs[i].len);
      e.tx   = (e.ntx == 0) ? 64'd0 : (64'(vecs[i].din) & lane_mask(e.ntx));
      check_run($sformatf("vec%0d", i), e);
    end

    // Asynchronous reset while the third byte is in flight.
    eng_L = 0; eng_B = 8; eng_en = 1'b1;
    tx_q.delete();
    @(negedge CLK);
    LEN = 3'd5; DIN = 40'h0504030201; START = 1'b1;
    n = 0;
    while (!(tx_q.size() == 3 && BUSY) && n < 500) begin
      @(negedge CLK);
      n++;
    end
    check("rst_reached_byte3", 64'(tx_q.size() == 3 && BUSY), 64'd1);
    @(negedge CLK);
    #2;
    RSTN = 1'b0;
    #1;
    check("rst_async_ss", 64'(SS), 64'd1);
    check("rst_async_getbyte", 64'(getByte), 64'd0);
    check("rst_async_dout", 64'(DOUT), 64'd0);
    check("rst_async_err", 64'(ERR), 64'd0);
    START = 1'b0;
    r_done = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge CLK);
      if (DONE) r_done++;
    end
    check("rst_no_done", 64'(r_done), 64'd0);
    check("rst_engine_idle", 64'(eng_busy), 64'd0);
    RSTN = 1'b1;
    @(negedge CLK);
    run_xfer(3'd5, 40'h0504030201, 0, 8, 1'b1, 0);
    check_run("post_rst", model(5, 40'h0504030201, 0, 8, 1'b1, 40'h0));

    prev = 40'hFAFBFCFDFE;
    for (int t = 0; t < 40; t++) begin
      rl  = 3'($urandom_range(0, 7));
      rd  = 40'({$urandom, $urandom});
      ra  = $urandom_range(0, 3);
      rb  = $urandom_range(1, 6);
      ren = ($urandom_range(0, 7) != 0);
      rh  = $urandom_range(0, 3);
      e = model(rl, rd, ra, rb, ren, prev);
      run_xfer(rl, rd, ra, rb, ren, rh);
      check_run($sformatf("rnd%0d", t), e);
      prev = e.dout;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
